// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default constants for the CPU step/run controller.
package cpu_ctrl_pkg;

   // Controller modes: waiting for a press, waiting for release, free-running.
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_REL = 2'd1,
      S_RUN      = 2'd2
   } state_t;

   // Stable cycles needed before a button level change is accepted.
   localparam int unsigned DEB_CYCLES_DEFAULT = 1000000;

   // Clock cycles per cpu_en pulse in free-run mode.
   localparam logic [31:0] RUN_DIV_DEFAULT = 32'd50000000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer.
// The clean level only follows the synchronized input after it has
// disagreed with the clean level for DEB_CYCLES consecutive cycles.
module btn_debounce
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic Clk,
   input  logic Reset,
   input  logic raw,
   output logic clean
);

   // Counter only needs to reach DEB_CYCLES-1.
   localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          clean_q, clean_d;

   // Count consecutive mismatch cycles; any agreeing cycle restarts the count.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      cnt_d   = '0;
      clean_d = clean_q;
      if (sync2_q != clean_q) begin
         if (cnt_q == CNT_LAST) begin
            clean_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchronizer, counter and clean level registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
      end
   end

   assign clean = clean_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU advance controller: single-step from a debounced button or
// free-run from a prescaler, producing a registered one-cycle cpu_en
// that gates PC and register-file updates in the Datapath.
module cpu_step_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
   parameter logic [31:0] RUN_DIV    = RUN_DIV_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        run_mode,
   input  logic        step_btn,
   input  logic        halt,
   output logic        cpu_en,
   output logic        btn_clean,
   output logic [31:0] cycle_count
);

   localparam logic [31:0] PRE_LAST = RUN_DIV - 32'd1;

   state_t      state_q, state_d;
   logic        run_sync1_q, run_sync1_d;
   logic        run_sync2_q, run_sync2_d;
   logic        clean_prev_q, clean_prev_d;
   logic [31:0] prescale_q, prescale_d;
   logic        cpu_en_q, cpu_en_d;
   logic [31:0] cycle_count_q, cycle_count_d;
   logic        clean;
   logic        btn_rise;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_btn_debounce (
      .Clk   (Clk),
      .Reset (Reset),
      .raw   (step_btn),
      .clean (clean)
   );

   assign btn_rise = clean & ~clean_prev_q;

   // FSM state register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a mode change always wins over a coincident step edge.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (run_sync2_q)           state_d = S_RUN;
            else if (btn_rise && !halt) state_d = S_WAIT_REL;
         end
         S_WAIT_REL: begin
            if (run_sync2_q)  state_d = S_RUN;
            else if (!clean)  state_d = S_IDLE;
         end
         S_RUN: begin
            if (!run_sync2_q) state_d = S_WAIT_REL;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs and datapath next values; halt blocks every pulse and freezes the prescaler.
   always_comb begin
      run_sync1_d   = run_mode;
      run_sync2_d   = run_sync1_q;
      clean_prev_d  = clean;
      prescale_d    = '0;
      cpu_en_d      = 1'b0;
      cycle_count_d = cycle_count_q + {31'd0, cpu_en_q};
      if (state_q == S_RUN && state_d == S_RUN) begin
         if (halt)                       prescale_d = prescale_q;
         else if (prescale_q == PRE_LAST) prescale_d = '0;
         else                            prescale_d = prescale_q + 32'd1;
      end
      if (!halt) begin
         if (state_q == S_IDLE && btn_rise && !run_sync2_q) cpu_en_d = 1'b1;
         if (state_q == S_RUN && run_sync2_q && prescale_q == PRE_LAST) cpu_en_d = 1'b1;
      end
   end

   // Datapath registers: synchronizer, edge history, prescaler, pulse, counter.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         run_sync1_q   <= 1'b0;
         run_sync2_q   <= 1'b0;
         clean_prev_q  <= 1'b0;
         prescale_q    <= '0;
         cpu_en_q      <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         run_sync1_q   <= run_sync1_d;
         run_sync2_q   <= run_sync2_d;
         clean_prev_q  <= clean_prev_d;
         prescale_q    <= prescale_d;
         cpu_en_q      <= cpu_en_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign cpu_en      = cpu_en_q;
   assign btn_clean   = clean;
   assign cycle_count = cycle_count_q;

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 1000000: consecutive stable cycles that qualify a button level change.
REQ-002 The block SHALL have parameter RUN_DIV, default 50000000: Clk cycles per cpu_en pulse in run mode; legal range 1 to 2^32-1.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port run_mode, input, 1 bit: 1 selects free-run, 0 selects single-step; asynchronous switch.
REQ-006 The block SHALL have port step_btn, input, 1 bit: raw, asynchronous, bouncing push-button.
REQ-007 The block SHALL have port halt, input, 1 bit: synchronous stop request from the Datapath.
REQ-008 The block SHALL have port cpu_en, output, 1 bit: one-cycle advance enable for the Datapath.
REQ-009 The block SHALL have port btn_clean, output, 1 bit: synchronized, debounced step_btn level.
REQ-010 The block SHALL have port cycle_count, output, 32 bits: number of cpu_en pulses issued since reset.

Function
REQ-011 step_btn and run_mode SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 btn_clean SHALL change only after the synchronized button differs from btn_clean for DEB_CYCLES consecutive cycles; any mismatch-free cycle or level return SHALL clear the stability count.
REQ-013 The FSM SHALL have states S_IDLE, S_WAIT_REL and S_RUN.
REQ-014 In S_IDLE, a btn_clean rising edge with halt low SHALL drive cpu_en high for exactly the next cycle and move the FSM to S_WAIT_REL.
REQ-015 S_WAIT_REL SHALL issue no cpu_en and SHALL return to S_IDLE when btn_clean is low, so one press yields exactly one pulse.
REQ-016 The FSM SHALL go from S_IDLE or S_WAIT_REL to S_RUN when the synchronized run_mode is 1.
REQ-017 The FSM SHALL go from S_RUN to S_WAIT_REL when the synchronized run_mode is 0, so a held button does not step.
REQ-018 In S_RUN, a prescaler SHALL count 0 to RUN_DIV-1 and wrap to 0; cpu_en SHALL be high in the cycle the count equals RUN_DIV-1.
REQ-019 With RUN_DIV=1, cpu_en SHALL be high every cycle in S_RUN.
REQ-020 The prescaler SHALL clear to 0 on every entry into S_RUN, so the first pulse comes RUN_DIV cycles after entry.
REQ-021 halt high SHALL force cpu_en low in every state (highest priority).
REQ-022 While halt is high, the prescaler SHALL hold its value, and a step edge seen in S_IDLE SHALL be discarded with no later pulse.
REQ-023 cpu_en SHALL be a registered output, with no combinational path from any input.
REQ-024 cycle_count SHALL increment by 1 in the cycle after each cpu_en pulse and SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 Simultaneous mode change and step edge SHALL resolve to the mode transition; no step pulse SHALL be issued.

Reset
REQ-026 On Reset high at a Clk edge, the FSM SHALL be S_IDLE, the prescaler and debounce counters 0, synchronizer flops 0, btn_clean 0, cpu_en 0 and cycle_count 0.
REQ-027 Reset asserted mid-debounce or mid-prescale SHALL abandon the operation with no cpu_en pulse in the reset cycle or the cycle after.
REQ-028 After Reset deasserts with run_mode held at 1, the FSM SHALL enter S_RUN within 3 cycles.

Structure
REQ-029 The FSM state typedef and the DEB_CYCLES and RUN_DIV default constants SHALL live in the shared package cpu_ctrl_pkg.
REQ-030 The synchronizer and debounce logic SHALL be one sub-module, btn_debounce, with ports Clk, Reset, raw, clean and DEB_CYCLES passed as a parameter.
REQ-031 cpu_step_ctrl SHALL sit upstream of Datapath, with cpu_en gating PC and register-file update.

Verification (all with DEB_CYCLES=4, RUN_DIV=3)
REQ-032 Clean press: step_btn high for 20 cycles -> exactly one cpu_en pulse, 7 cycles after the raise (2 sync + 4 stable + 1); cycle_count=1.
REQ-033 Bounce: step_btn toggled every 2 cycles for 16 cycles, then low -> btn_clean stays 0, no cpu_en, cycle_count=0.
REQ-034 Run mode: run_mode=1 for 30 cycles after sync -> cpu_en every 3rd cycle, first pulse 3 cycles after S_RUN entry, cycle_count=10 at end.
REQ-035 Halt: halt high during run for 9 cycles -> no pulses; after release, the next pulse comes at the held prescaler phase.
REQ-036 Reset mid-run with prescaler=1 -> all outputs 0 next cycle; re-entry to S_RUN restarts the prescaler from 0.
REQ-037 Wrap: cycle_count preloaded to 0xFFFFFFFF via force, one step -> cycle_count=0.
